// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 4-stage pipeline: register and N/Z scoreboard, branch and memory-wait FSM.
// Optional memory-wait abort is enabled by defining HAZARD_MEM_TIMEOUT_EN.
module pipeline_hazard_ctrl #(
    parameter int NREG        = 8,
    parameter int RIDX_W      = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [NREG-1:0]   dec_rd_mask,
    input  logic              dec_wr_en,
    input  logic [RIDX_W-1:0] dec_wr_idx,
    input  logic              dec_reads_nz,
    input  logic              dec_writes_nz,
    input  logic              dec_is_branch,
    input  logic              ex_br_resolve,
    input  logic              ex_br_taken,
    input  logic              ex_mem_req,
    input  logic              mem_ready,
    input  logic              wb_valid,
    input  logic              wb_wr_en,
    input  logic [RIDX_W-1:0] wb_wr_idx,
    input  logic              wb_writes_nz,
    output logic              pc_enable,
    output logic              stall_decode,
    output logic              bubble_ex,
    output logic              hold_back,
    output logic              flush,
    output logic [NREG-1:0]   busy_mask,
    output logic [1:0]        nz_cnt,
    output logic [1:0]        state,
    output logic              err
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_BR_PEND  = 2'd1;
    localparam logic [1:0] ST_BR_FLUSH = 2'd2;
    localparam logic [1:0] ST_MEM_WAIT = 2'd3;

    logic [1:0]      state_reg, state_next;
    logic [NREG-1:0] busy_reg, busy_next;
    logic [1:0]      nz_cnt_reg, nz_cnt_next;
    logic            err_reg, err_next;

    logic [NREG-1:0] clr_vec, dec_wr_vec;
    logic            hazard, issue, nz_inc, nz_dec, nz_busy, nz_underflow, timeout_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_onehot
            assign clr_vec[gi]    = wb_valid & wb_wr_en & (wb_wr_idx == RIDX_W'(gi));
            assign dec_wr_vec[gi] = (dec_wr_idx == RIDX_W'(gi));
        end
    endgenerate

    // Retirement in writeback is visible to decode in the same cycle (write-first regfile).
    assign nz_dec  = wb_valid & wb_writes_nz;
    assign nz_busy = nz_cnt_reg > {1'b0, nz_dec};

    assign hazard = dec_valid & ( (|(dec_rd_mask & busy_reg & ~clr_vec))
                                | (dec_wr_en & (|(dec_wr_vec & busy_reg & ~clr_vec)))
                                | (dec_reads_nz & nz_busy)
                                | (dec_writes_nz & (nz_cnt_reg == 2'd3)) );

    assign issue  = (state_reg == ST_RUN) & dec_valid & ~hazard & ~ex_mem_req;
    assign nz_inc = issue & dec_writes_nz;

    // Set wins over clear on the same index.
    assign busy_next    = (busy_reg & ~clr_vec) | ({NREG{issue & dec_wr_en}} & dec_wr_vec);
    assign nz_underflow = nz_dec & ~nz_inc & (nz_cnt_reg == 2'd0);

    always_comb begin
        nz_cnt_next = nz_cnt_reg;
        if (nz_inc && !nz_dec)
            nz_cnt_next = nz_cnt_reg + 2'd1;
        else if (nz_dec && !nz_inc && nz_cnt_reg != 2'd0)
            nz_cnt_next = nz_cnt_reg - 2'd1;
    end

`ifdef HAZARD_MEM_TIMEOUT_EN
    logic [3:0] wait_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt_reg <= 4'd0;
        else if (state_reg != ST_MEM_WAIT)
            wait_cnt_reg <= 4'd0;
        else if (!mem_ready)
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
    end
`endif

    always_comb begin
        state_next   = state_reg;
        pc_enable    = 1'b1;
        stall_decode = 1'b0;
        bubble_ex    = 1'b0;
        hold_back    = 1'b0;
        flush        = 1'b0;
        timeout_hit  = 1'b0;
        case (state_reg)
            ST_RUN: begin
                pc_enable    = ~hazard;
                stall_decode = hazard;
                bubble_ex    = hazard;
                if (ex_mem_req && !mem_ready)
                    state_next = ST_MEM_WAIT;
                else if (issue && dec_is_branch)
                    state_next = ST_BR_PEND;
            end
            ST_BR_PEND: begin
                pc_enable    = 1'b0;
                stall_decode = 1'b1;
                bubble_ex    = 1'b1;
                // A memory request shadows any branch resolution in the same cycle.
                if (ex_mem_req && !mem_ready)
                    state_next = ST_MEM_WAIT;
                else if (!ex_mem_req && ex_br_resolve)
                    state_next = ex_br_taken ? ST_BR_FLUSH : ST_RUN;
            end
            ST_BR_FLUSH: begin
                flush      = 1'b1;
                bubble_ex  = 1'b1;
                state_next = ST_RUN;
            end
            default: begin
                pc_enable    = 1'b0;
                stall_decode = 1'b1;
                hold_back    = ~mem_ready;
                if (mem_ready)
                    state_next = ST_RUN;
`ifdef HAZARD_MEM_TIMEOUT_EN
                else if (wait_cnt_reg == 4'(MEM_TIMEOUT - 1)) begin
                    state_next  = ST_RUN;
                    timeout_hit = 1'b1;
                end
`endif
            end
        endcase
    end

    assign err_next = err_reg | nz_underflow | (ex_mem_req & ex_br_resolve) | timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_RUN;
            busy_reg   <= '0;
            nz_cnt_reg <= 2'd0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            busy_reg   <= busy_next;
            nz_cnt_reg <= nz_cnt_next;
            err_reg    <= err_next;
        end
    end

    assign busy_mask = busy_reg;
    assign nz_cnt    = nz_cnt_reg;
    assign state     = state_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: random and directed stimulus against a behavioural model.
// Honours HAZARD_MEM_TIMEOUT_EN in the model so either build can be checked.
module tb_pipeline_hazard_ctrl;

    localparam int S_RUN = 0, S_BRP = 1, S_BRF = 2, S_MEM = 3;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        bit       dv;
        bit [7:0] rd;
        bit       wen;
        bit [2:0] widx;
        bit       rnz, wnz, br, res, tkn, mreq, mrdy, wbv, wbwen;
        bit [2:0] wbidx;
        bit       wbnz;
    } stim_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dec_valid, dec_wr_en, dec_reads_nz, dec_writes_nz, dec_is_branch;
    logic [7:0] dec_rd_mask;
    logic [2:0] dec_wr_idx, wb_wr_idx;
    logic       ex_br_resolve, ex_br_taken, ex_mem_req, mem_ready;
    logic       wb_valid, wb_wr_en, wb_writes_nz;
    logic       pc_enable, stall_decode, bubble_ex, hold_back, flush, err;
    logic [7:0] busy_mask;
    logic [1:0] nz_cnt, state;

    pipeline_hazard_ctrl #(.NREG(8), .RIDX_W(3), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_rd_mask(dec_rd_mask), .dec_wr_en(dec_wr_en),
        .dec_wr_idx(dec_wr_idx), .dec_reads_nz(dec_reads_nz), .dec_writes_nz(dec_writes_nz),
        .dec_is_branch(dec_is_branch), .ex_br_resolve(ex_br_resolve), .ex_br_taken(ex_br_taken),
        .ex_mem_req(ex_mem_req), .mem_ready(mem_ready), .wb_valid(wb_valid), .wb_wr_en(wb_wr_en),
        .wb_wr_idx(wb_wr_idx), .wb_writes_nz(wb_writes_nz), .pc_enable(pc_enable),
        .stall_decode(stall_decode), .bubble_ex(bubble_ex), .hold_back(hold_back), .flush(flush),
        .busy_mask(busy_mask), .nz_cnt(nz_cnt), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    logic [17:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Behavioural model of the controller.
    int m_state = S_RUN;
    bit m_busy[8];
    int m_nz = 0;
    bit m_err = 1'b0;
    int m_wait = 0;

    function automatic logic [17:0] dut_vec();
        return {pc_enable, stall_decode, bubble_ex, hold_back, flush, busy_mask, nz_cnt, state, err};
    endfunction

    task automatic compare(input string name, input logic [17:0] e);
        logic [17:0] a;
        a = dut_vec();
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got ctl=%b busy=%h nz=%0d st=%0d err=%b, want ctl=%b busy=%h nz=%0d st=%0d err=%b",
                     name, a[17:13], a[12:5], a[4:3], a[2:1], a[0], e[17:13], e[12:5], e[4:3], e[2:1], e[0]);
        end else begin
            $display("vec %0d %s ok ctl=%b busy=%h nz=%0d st=%0d err=%b",
                     vectors, name, a[17:13], a[12:5], a[4:3], a[2:1], a[0]);
        end
    endtask

    always @(negedge clk) begin
        logic [17:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare("cycle", e);
        end
    end

    task automatic drive(input stim_t s);
        dec_valid = s.dv; dec_rd_mask = s.rd; dec_wr_en = s.wen; dec_wr_idx = s.widx;
        dec_reads_nz = s.rnz; dec_writes_nz = s.wnz; dec_is_branch = s.br;
        ex_br_resolve = s.res; ex_br_taken = s.tkn; ex_mem_req = s.mreq; mem_ready = s.mrdy;
        wb_valid = s.wbv; wb_wr_en = s.wbwen; wb_wr_idx = s.wbidx; wb_writes_nz = s.wbnz;
    endtask

    task automatic model_reset();
        m_state = S_RUN; m_nz = 0; m_err = 1'b0; m_wait = 0;
        for (int r = 0; r < 8; r++) m_busy[r] = 1'b0;
    endtask

    // Drive one cycle, push what the controller should show, advance the model to the next cycle.
    task automatic step(input stim_t s);
        int clr, nz_inc, nz_dec;
        bit hz, iss, pc, st, bub, hold, fl;
        logic [7:0] bm;
        drive(s);
        clr = (s.wbv && s.wbwen) ? int'(s.wbidx) : -1;
        hz = 1'b0;
        for (int r = 0; r < 8; r++)
            if (s.rd[r] && m_busy[r] && r != clr) hz = 1'b1;
        if (s.wen && m_busy[s.widx] && int'(s.widx) != clr) hz = 1'b1;
        nz_dec = (s.wbv && s.wbnz) ? 1 : 0;
        if (s.rnz && (m_nz - nz_dec) > 0) hz = 1'b1;
        if (s.wnz && m_nz == 3) hz = 1'b1;
        hz = hz && s.dv;
        iss = (m_state == S_RUN) && s.dv && !hz && !s.mreq;
        case (m_state)
            S_RUN:   {pc, st, bub, hold, fl} = {!hz, hz, hz, 1'b0, 1'b0};
            S_BRP:   {pc, st, bub, hold, fl} = 5'b01100;
            S_BRF:   {pc, st, bub, hold, fl} = 5'b10101;
            default: {pc, st, bub, hold, fl} = {1'b0, 1'b1, 1'b0, !s.mrdy, 1'b0};
        endcase
        for (int r = 0; r < 8; r++) bm[r] = m_busy[r];
        exp_q.push_back({pc, st, bub, hold, fl, bm, 2'(m_nz), 2'(m_state), m_err});

        if (clr >= 0) m_busy[clr] = 1'b0;
        if (iss && s.wen) m_busy[s.widx] = 1'b1;
        nz_inc = (iss && s.wnz) ? 1 : 0;
        if (nz_dec == 1 && nz_inc == 0 && m_nz == 0) m_err = 1'b1;
        else m_nz = m_nz + nz_inc - nz_dec;
        if (s.mreq && s.res) m_err = 1'b1;
        case (m_state)
            S_RUN: begin
                if (s.mreq && !s.mrdy) begin m_state = S_MEM; m_wait = 0; end
                else if (iss && s.br) m_state = S_BRP;
            end
            S_BRP: begin
                if (s.mreq && !s.mrdy) begin m_state = S_MEM; m_wait = 0; end
                else if (!s.mreq && s.res) m_state = s.tkn ? S_BRF : S_RUN;
            end
            S_BRF: m_state = S_RUN;
            default: begin
                if (s.mrdy) m_state = S_RUN;
`ifdef HAZARD_MEM_TIMEOUT_EN
                else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin m_state = S_RUN; m_err = 1'b1; end
                end
`endif
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    // Asserted between clock edges: outputs must reflect reset without waiting for a clock.
    task automatic do_reset();
        stim_t s;
        s = '0;
        reset = 1'b0;
        #1;
        compare("async_reset", {5'b10000, 8'h00, 2'd0, 2'd0, 1'b0});
        drive(s);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t wr(input int idx);
        stim_t s;
        s = '0; s.dv = 1'b1; s.wen = 1'b1; s.widx = 3'(idx);
        return s;
    endfunction

    function automatic stim_t retire(input int idx, input bit nz);
        stim_t s;
        s = '0; s.wbv = 1'b1; s.wbwen = 1'b1; s.wbidx = 3'(idx); s.wbnz = nz;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int busy_list[$];
        s = '0;
        s.dv    = ($urandom_range(0, 3) != 0);
        s.rd    = 8'($urandom & $urandom & $urandom);
        s.wen   = $urandom_range(0, 1) == 1;
        s.widx  = 3'($urandom_range(0, 7));
        s.rnz   = $urandom_range(0, 4) == 0;
        s.wnz   = $urandom_range(0, 2) == 0;
        s.br    = $urandom_range(0, 6) == 0;
        s.res   = (m_state == S_BRP) && ($urandom_range(0, 4) < 2);
        s.tkn   = $urandom_range(0, 1) == 1;
        s.mreq  = (m_state == S_MEM) || ((m_state == S_RUN) && $urandom_range(0, 7) == 0);
        s.mrdy  = $urandom_range(0, 4) < 2;
        s.wbv   = (m_state != S_MEM) && $urandom_range(0, 1) == 1;
        s.wbwen = $urandom_range(0, 9) < 7;
        for (int r = 0; r < 8; r++) if (m_busy[r]) busy_list.push_back(r);
        if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
            s.wbidx = 3'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
        else
            s.wbidx = 3'($urandom_range(0, 7));
        s.wbnz  = (m_nz > 0) && $urandom_range(0, 4) < 2;
        return s;
    endfunction

    initial begin
        stim_t s;
        s = '0;
        drive(s);
        model_reset();
        #12;
        compare("reset_state", {5'b10000, 8'h00, 2'd0, 2'd0, 1'b0});
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 1200; i++) step(rand_stim());

        do_reset();
        // RAW on r3: stall until r3 retires, dropping in the retire cycle.
        step(wr(3));
        s = '0; s.dv = 1'b1; s.rd = 8'h08;
        step(s); step(s);
        s.wbv = 1'b1; s.wbwen = 1'b1; s.wbidx = 3'd3;
        step(s);
        s = '0; step(s);
        // Same-cycle set and clear of r5.
        step(wr(5));
        s = wr(5); s.wbv = 1'b1; s.wbwen = 1'b1; s.wbidx = 3'd5;
        step(s);
        step(retire(5, 1'b0));
        s = '0; step(s);
        // Taken then not-taken branch.
        for (int t = 1; t >= 0; t--) begin
            s = '0; s.dv = 1'b1; s.br = 1'b1; step(s);
            s = '0; step(s);
            s.res = 1'b1; s.tkn = 1'(t); step(s);
            s = '0; step(s); step(s);
        end
        // Memory wait of three cycles with a reader in decode.
        s = '0; s.dv = 1'b1; s.rd = 8'h01; s.mreq = 1'b1;
        step(s); step(s); step(s);
        s.mrdy = 1'b1; step(s);
        s = '0; step(s);
        // N/Z tracking.
        s = '0; s.dv = 1'b1; s.wnz = 1'b1; step(s); step(s);
        s = '0; s.dv = 1'b1; s.rnz = 1'b1; s.br = 1'b1; step(s);
        s.wbv = 1'b1; s.wbnz = 1'b1; step(s); step(s);
        s = '0; s.res = 1'b1; step(s);
        s = '0; s.dv = 1'b1; s.wnz = 1'b1;
        step(s); step(s); step(s); step(s); step(s);
        s = '0; s.wbv = 1'b1; s.wbnz = 1'b1;
        step(s); step(s); step(s);

        // Fill scoreboard and N/Z, enter MEM_WAIT, then reset asynchronously.
        do_reset();
        for (int r = 0; r < 8; r++) begin
            s = wr(r); s.wnz = (r < 2); step(s);
        end
        s = '0; s.mreq = 1'b1; step(s); step(s);
        do_reset();

        // Long memory wait: aborts only in the timeout build.
        s = '0; s.mreq = 1'b1;
        for (int i = 0; i < 18; i++) step(s);
        s.mrdy = 1'b1; step(s);
        s = '0; step(s); step(s);

        do_reset();
        s = '0; s.mreq = 1'b1; s.mrdy = 1'b1; s.res = 1'b1; s.tkn = 1'b1;
        step(s);
        s = '0; step(s); step(s);

        do_reset();
        step(retire(0, 1'b1));
        s = '0; step(s); step(s);

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 4-stage pipeline: Fetch, RegFile Read/Decode, Execute, RegFile Write.
- Tracks in-flight register and NZ writers with a scoreboard.
- Generates decode stalls, execute bubbles, fetch hold, branch flush, and memory-wait freeze.
- Sits beside the per-stage decoder; consumes decoded attributes of the decode-stage instruction and retirement info from writeback.

Parameters:
- NREG, 8, number of architectural registers (scoreboard width)
- RIDX_W, 3, register index width
- MEM_TIMEOUT, 15, max MEM_WAIT cycles before abort (used only with timeout feature)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- dec_valid  in  1  decode stage holds a valid instruction
- dec_rd_mask  in  NREG  one-hot-per-bit registers read by the decode instruction
- dec_wr_en  in  1  decode instruction writes a register
- dec_wr_idx  in  RIDX_W  destination register
- dec_reads_nz  in  1  decode instruction consumes N/Z (conditional branch)
- dec_writes_nz  in  1  decode instruction updates N/Z
- dec_is_branch  in  1  decode instruction is a branch
- ex_br_resolve  in  1  branch in Execute resolves this cycle
- ex_br_taken  in  1  resolved branch is taken (valid with ex_br_resolve)
- ex_mem_req  in  1  load/store in Execute requests memory
- mem_ready  in  1  memory completes the access
- wb_valid  in  1  instruction retiring in RegFile Write
- wb_wr_en  in  1  retiring instruction writes a register
- wb_wr_idx  in  RIDX_W  retiring destination
- wb_writes_nz  in  1  retiring instruction updated N/Z
- pc_enable  out  1  PC/fetch register advance
- stall_decode  out  1  hold decode stage register
- bubble_ex  out  1  inject NOP into Execute
- hold_back  out  1  freeze Execute and RegFile Write stages
- flush  out  1  kill fetch and decode contents
- busy_mask  out  NREG  scoreboard contents
- nz_cnt  out  2  in-flight NZ writers
- state  out  2  FSM state: RUN=0, BR_PEND=1, BR_FLUSH=2, MEM_WAIT=3
- err  out  1  sticky protocol/timeout error

Behaviour:
- Reset (reset=0, async): state=RUN, busy_mask=0, nz_cnt=0, err=0, timeout counter=0. Outputs during reset: pc_enable=1, stall_decode=0, bubble_ex=0, hold_back=0, flush=0.
- clr_vec = one-hot(wb_wr_idx) when wb_valid&wb_wr_en, else 0. Writeback retirement is visible the same cycle (write-first register file).
- hazard = dec_valid & ( |(dec_rd_mask & busy_mask & ~clr_vec) | (dec_wr_en & busy_mask[dec_wr_idx] & ~clr_vec[dec_wr_idx]) | (dec_reads_nz & nz_cnt_eff!=0) | (dec_writes_nz & nz_cnt==3) ).
  - nz_cnt_eff = nz_cnt − (wb_valid&wb_writes_nz).
- issue = state==RUN & dec_valid & ~hazard & ~ex_mem_req.
- Scoreboard next = (busy_mask & ~clr_vec) | (issue&dec_wr_en ? one-hot(dec_wr_idx) : 0). Same-index set and clear in one cycle: set wins.
- nz_cnt next = nz_cnt + (issue&dec_writes_nz) − (wb_valid&wb_writes_nz); simultaneous inc and dec leaves it unchanged. Decrement at 0 is ignored and sets err.
- RUN:
  - stall_decode=hazard; bubble_ex=hazard; pc_enable=~hazard.
  - ex_mem_req & ~mem_ready → MEM_WAIT. ex_mem_req & mem_ready completes in one cycle, with no state change.
  - issue & dec_is_branch → BR_PEND.
- BR_PEND:
  - pc_enable=0, stall_decode=1, bubble_ex=1.
  - ex_br_resolve & ex_br_taken → BR_FLUSH.
  - ex_br_resolve & ~ex_br_taken → RUN.
- BR_FLUSH (exactly 1 cycle): flush=1, pc_enable=1 (loads target), bubble_ex=1, stall_decode=0; then → RUN.
- MEM_WAIT:
  - pc_enable=0, stall_decode=1, hold_back=1, bubble_ex=0.
  - mem_ready → RUN; hold_back drops in the same cycle mem_ready is seen.
- Priority: ex_mem_req & ex_br_resolve in the same cycle is illegal. MEM_WAIT/memory handling wins, the branch is ignored, and err=1.
- Flushed instructions never issued, so the scoreboard needs no rollback.
- Reset mid-operation aborts any state to RUN with cleared scoreboard.

Optional Feature:
- Macro HAZARD_MEM_TIMEOUT_EN.
- Defined:
  - A 4-bit counter increments each MEM_WAIT cycle and clears on entry.
  - When it reaches MEM_TIMEOUT without mem_ready: → RUN, err=1, hold_back released.
- Undefined: no counter; MEM_WAIT waits indefinitely for mem_ready.

Test Plan:
- RAW stall: issue add writing r3 (cycle 0), next decode reads r3 (dec_rd_mask=8'h08) → stall_decode=1, bubble_ex=1 until the cycle wb retires r3; stall drops that same cycle; busy_mask returns to 0.
- Set/clear collision: busy_mask=8'h20, wb retires r5 while decode issues a write to r5 → no stall, busy_mask stays 8'h20.
- Taken branch: issue branch → state=1, pc_enable=0; ex_br_resolve=1, ex_br_taken=1 → state=2, flush=1 for exactly 1 cycle, then state=0. Repeat not-taken → directly state=0, flush never asserted.
- Memory wait: ex_mem_req=1, mem_ready=0 for 3 cycles then 1 → state=3 for 3 cycles with hold_back=1, stall_decode=1; RUN on the ready cycle.
- NZ tracking: issue cmp then sub (nz_cnt=2); a conditional branch in decode stalls until both retire; a 4th NZ writer stalls at nz_cnt=3.
- Reset in MEM_WAIT with busy_mask=8'hFF, nz_cnt=2: drive reset=0 asynchronously → immediately state=0, busy_mask=0, nz_cnt=0, err=0, pc_enable=1. With HAZARD_MEM_TIMEOUT_EN, hold mem_ready=0 for 15 cycles → err=1, state=0.
